// File: rtl/bus_interface.sv
// Load/store unit between the CPU and the word-wide RAM: turns byte/half/word
// requests into lane strobes and RAM controls, aligns load data, rejects bad accesses.
module bus_interface #(
  parameter logic [31:0] MEM_BASE      = 32'h0000_0000,
  parameter int unsigned MEM_ADDR_BITS = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        write,
  input  logic [1:0]  cycle_width,
  input  logic        sign_extend,
  input  logic [31:0] address,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        ready,
  output logic        bus_error,
  output logic        mem_cs,
  output logic [29:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic [3:0]  mem_data_strobes,
  output logic        mem_read,
  output logic        mem_write
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    W_BYTE    = 2'b00,
    W_HALF    = 2'b01,
    W_WORD    = 2'b10,
    W_ILLEGAL = 2'b11
  } width_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  width_e      width_q, width_d;
  logic        sign_q, sign_d;
  logic [1:0]  offset_q, offset_d;
  logic        err_q, err_d;
  logic        mem_cs_q, mem_cs_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [29:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_out_q, mem_data_out_d;
  logic [3:0]  strobes_q, strobes_d;
  logic        ready_q, ready_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] cpu_data_out_q, cpu_data_out_d;

  width_e      req_width;
  logic        req_error;
  logic [3:0]  req_strobes;
  logic [31:0] req_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_aligned;

  // Request decode: big-endian lane mapping, store-data replication, legality.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    req_width   = width_e'(cycle_width);
    req_strobes = 4'b0000;
    req_data    = 32'h0;
    req_error   = (address[31:MEM_ADDR_BITS] != MEM_BASE[31:MEM_ADDR_BITS]);
    case (req_width)
      W_BYTE: begin
        req_strobes = 4'b1000 >> address[1:0];
        req_data    = {4{cpu_data_in[7:0]}};
      end
      W_HALF: begin
        req_error   = req_error | address[0];
        req_strobes = address[1] ? 4'b0011 : 4'b1100;
        req_data    = {2{cpu_data_in[15:0]}};
      end
      W_WORD: begin
        req_error   = req_error | (address[1:0] != 2'b00);
        req_strobes = 4'b1111;
        req_data    = cpu_data_in;
      end
      default: req_error = 1'b1;
    endcase
  end

  // Load alignment: pick the addressed lane(s) and extend into the upper bits.
  always_comb begin
    rd_byte    = mem_data_in[{~offset_q, 3'b000} +: 8];
    rd_half    = offset_q[1] ? mem_data_in[15:0] : mem_data_in[31:16];
    rd_aligned = mem_data_in;
    case (width_q)
      W_BYTE:  rd_aligned = {{24{sign_q & rd_byte[7]}}, rd_byte};
      W_HALF:  rd_aligned = {{16{sign_q & rd_half[15]}}, rd_half};
      default: rd_aligned = mem_data_in;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    width_d        = width_q;
    sign_d         = sign_q;
    offset_d       = offset_q;
    err_d          = err_q;
    cpu_data_out_d = cpu_data_out_q;
    mem_cs_d       = 1'b0;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    mem_address_d  = 30'h0;
    mem_data_out_d = 32'h0;
    strobes_d      = 4'b0000;
    ready_d        = 1'b0;
    bus_error_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          write_d  = write;
          width_d  = req_width;
          sign_d   = sign_extend;
          offset_d = address[1:0];
          err_d    = req_error;
          if (req_error) begin
            state_d = COMPLETE;
          end else begin
            state_d        = ACCESS;
            mem_cs_d       = 1'b1;
            mem_read_d     = !write;
            mem_write_d    = write;
            mem_address_d  = address[31:2];
            mem_data_out_d = req_data;
            strobes_d      = req_strobes;
          end
        end
      end
      ACCESS: begin
        // The RAM has registered its read data on the falling edge of this cycle.
        if (!write_q) cpu_data_out_d = rd_aligned;
        state_d = COMPLETE;
      end
      COMPLETE: begin
        ready_d     = 1'b1;
        bus_error_d = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values computed before the edge regardless of process order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      width_q        <= W_BYTE;
      sign_q         <= 1'b0;
      offset_q       <= 2'b00;
      err_q          <= 1'b0;
      mem_cs_q       <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= 30'h0;
      mem_data_out_q <= 32'h0;
      strobes_q      <= 4'b0000;
      ready_q        <= 1'b0;
      bus_error_q    <= 1'b0;
      cpu_data_out_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      width_q        <= width_d;
      sign_q         <= sign_d;
      offset_q       <= offset_d;
      err_q          <= err_d;
      mem_cs_q       <= mem_cs_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      strobes_q      <= strobes_d;
      ready_q        <= ready_d;
      bus_error_q    <= bus_error_d;
      cpu_data_out_q <= cpu_data_out_d;
    end
  end

  assign cpu_data_out     = cpu_data_out_q;
  assign ready            = ready_q;
  assign bus_error        = bus_error_q;
  assign mem_cs           = mem_cs_q;
  assign mem_address      = mem_address_q;
  assign mem_data_out     = mem_data_out_q;
  assign mem_data_strobes = strobes_q;
  assign mem_read         = mem_read_q;
  assign mem_write        = mem_write_q;

endmodule

// File: tb/tb_bus_interface.sv
// Scoreboard bench for bus_interface: a byte-array memory model predicts every
// RAM access and completion; a negedge monitor compares them as the DUT emits them.
module tb_bus_interface;

  localparam logic [31:0] MEM_BASE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  cycle_width = 2'b00;
  logic        sign_extend = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] cpu_data_in = 32'h0;
  logic [31:0] mem_data_in = 32'h0;
  logic [31:0] cpu_data_out;
  logic        ready;
  logic        bus_error;
  logic        mem_cs;
  logic [29:0] mem_address;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_data_strobes;
  logic        mem_read;
  logic        mem_write;

  bus_interface #(.MEM_BASE(MEM_BASE), .MEM_ADDR_BITS(12)) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .write            (write),
    .cycle_width      (cycle_width),
    .sign_extend      (sign_extend),
    .address          (address),
    .cpu_data_in      (cpu_data_in),
    .cpu_data_out     (cpu_data_out),
    .ready            (ready),
    .bus_error        (bus_error),
    .mem_cs           (mem_cs),
    .mem_address      (mem_address),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .mem_data_strobes (mem_data_strobes),
    .mem_read         (mem_read),
    .mem_write        (mem_write)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM seen by the DUT: acts on the falling edge while selected.
  logic [31:0] ram [0:1023];
  always @(negedge clock) begin
    if (mem_cs) begin
      if (mem_write)
        for (int l = 0; l < 4; l++)
          if (mem_data_strobes[l]) ram[mem_address[9:0]][8*l +: 8] <= mem_data_out[8*l +: 8];
      if (mem_read) mem_data_in <= ram[mem_address[9:0]];
    end
  end

  // Reference model: byte-addressed, big-endian memory image.
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] last_load = 32'h0;

  typedef struct {
    int          ccyc;
    logic        wr;
    logic [29:0] waddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    int          rcyc;
    logic        err;
    logic [31:0] data;
  } resp_t;

  acc_t  acc_q[$];
  resp_t resp_q[$];

  function automatic int size_of(input logic [1:0] wd);
    return (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] wd, input logic [31:0] a);
    return (wd == 2'd3) || (wd == 2'd1 && a[0]) || (wd == 2'd2 && a[1:0] != 2'd0) ||
           (a[31:12] != MEM_BASE[31:12]);
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] wd, input logic [31:0] a);
    logic [3:0] s;
    int off = int'(a[1:0]);
    int sz  = size_of(wd);
    for (int lane = 0; lane < 4; lane++) s[lane] = ((3 - lane) >= off) && ((3 - lane) < off + sz);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] wd, input logic [31:0] d);
    logic [31:0] w;
    int sz = size_of(wd);
    for (int lane = 0; lane < 4; lane++) w[8*lane +: 8] = d[8*(sz - 1 - ((3 - lane) % sz)) +: 8];
    return w;
  endfunction

  task automatic model_store(input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d);
    int base = int'({a[11:2], 2'b00});
    int off  = int'(a[1:0]);
    int sz   = size_of(wd);
    for (int o = off; o < off + sz; o++) ref_mem[base + o] = d[8*(sz - 1 - (o % sz)) +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] wd, input logic sx, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int base = int'({a[11:2], 2'b00});
    int off  = int'(a[1:0]);
    int sz   = size_of(wd);
    for (int o = off; o < off + sz; o++) v = (v << 8) | {24'h0, ref_mem[base + o]};
    if (sx && sz < 4 && v[8*sz - 1]) v = v | ~((32'h1 << (8*sz)) - 32'h1);
    return v;
  endfunction

  // Drive one request at the current negedge; return once the next one may be driven.
  task automatic issue(input logic wr, input logic [1:0] wd, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input bit hold);
    int    k;
    bit    err;
    acc_t  ae;
    resp_t re;
    req = 1'b1; write = wr; cycle_width = wd; sign_extend = sx; address = a; cpu_data_in = d;
    k   = cyc + 1;
    err = model_err(wd, a);
    if (!err) begin
      ae.ccyc = k; ae.wr = wr; ae.waddr = a[31:2];
      ae.strb = model_strb(wd, a); ae.wdata = model_wdata(wd, d);
      acc_q.push_back(ae);
      if (wr) model_store(wd, a, d);
      else    last_load = model_load(wd, sx, a);
    end
    re.rcyc = err ? k + 1 : k + 2; re.err = err; re.data = last_load;
    resp_q.push_back(re);
    @(negedge clock);
    if (!hold) req = 1'b0;
    while (cyc < re.rcyc) @(negedge clock);
  endtask

  // Monitor: compares RAM accesses and completions against the queued expectations.
  acc_t  mon_a;
  resp_t mon_r;
  always @(negedge clock) begin
    if (mem_cs) begin
      if (acc_q.size() == 0) check("unexpected_mem_cs", mem_cs, 1'b0);
      else begin
        mon_a = acc_q.pop_front();
        check("mem_cs_cycle", cyc, mon_a.ccyc);
        check("mem_read", mem_read, !mon_a.wr);
        check("mem_write", mem_write, mon_a.wr);
        check("mem_address", mem_address, mon_a.waddr);
        check("mem_data_strobes", mem_data_strobes, mon_a.strb);
        if (mon_a.wr) check("mem_data_out", mem_data_out, mon_a.wdata);
      end
    end else if (acc_q.size() != 0 && cyc > acc_q[0].ccyc) begin
      check("mem_cs_missing", mem_cs, 1'b1);
      void'(acc_q.pop_front());
    end
    if (ready) begin
      if (resp_q.size() == 0) check("unexpected_ready", ready, 1'b0);
      else begin
        mon_r = resp_q.pop_front();
        check("ready_cycle", cyc, mon_r.rcyc);
        check("bus_error", bus_error, mon_r.err);
        check("cpu_data_out", cpu_data_out, mon_r.data);
      end
    end else if (resp_q.size() != 0 && cyc > resp_q[0].rcyc) begin
      check("ready_timeout", ready, 1'b1);
      void'(resp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [1:0]  wd;
    int          bad;
    int          k;
    acc_t        ae;

    for (int w = 0; w < 1024; w++) begin
      r = $urandom;
      ram[w] = r;
      ref_mem[4*w] = r[31:24]; ref_mem[4*w+1] = r[23:16];
      ref_mem[4*w+2] = r[15:8]; ref_mem[4*w+3] = r[7:0];
    end

    repeat (3) @(negedge clock);
    check("reset_outputs",
          {ready, bus_error, mem_cs, mem_read, mem_write, mem_data_strobes},
          {23'h0, 9'h0});
    check("reset_cpu_data_out", cpu_data_out, 32'h0);
    check("reset_mem_address", mem_address, 30'h0);
    reset = 1'b0;
    @(negedge clock);

    // Word store then load.
    issue(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b0);

    // Byte loads of 0x80F17F01 at every offset, both extensions.
    issue(1'b1, 2'd2, 1'b0, 32'h040, 32'h80F17F01, 1'b0);
    for (int o = 0; o < 4; o++) begin
      issue(1'b0, 2'd0, 1'b1, 32'h040 + o, 32'h0, 1'b0);
      issue(1'b0, 2'd0, 1'b0, 32'h040 + o, 32'h0, 1'b0);
    end
    issue(1'b0, 2'd1, 1'b1, 32'h040, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h042, 32'h0, 1'b0);

    // Half store into the low half, then word read back.
    issue(1'b1, 2'd1, 1'b0, 32'h022, 32'h0000_1234, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 1'b0);

    // Rejected accesses.
    issue(1'b0, 2'd2, 1'b0, 32'h013, 32'h0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h005, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h1111_1111, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 1'b0);

    // Reset during ACCESS of a load: the RAM access happens, no completion follows.
    req = 1'b1; write = 1'b0; cycle_width = 2'd2; sign_extend = 1'b0; address = 32'h010;
    k = cyc + 1;
    ae.ccyc = k; ae.wr = 1'b0; ae.waddr = 30'h4; ae.strb = 4'hF; ae.wdata = 32'h0;
    acc_q.push_back(ae);
    @(negedge clock);
    req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("abort_outputs",
          {ready, bus_error, mem_cs, mem_read, mem_write, mem_data_strobes}, 32'h0);
    check("abort_cpu_data_out", cpu_data_out, 32'h0);
    check("abort_mem_address", mem_address, 30'h0);
    check("abort_mem_data_out", mem_data_out, 32'h0);
    reset = 1'b0;
    last_load = 32'h0;
    repeat (4) @(negedge clock);
    issue(1'b0, 2'd2, 1'b0, 32'h044, 32'h0, 1'b0);

    // Back-to-back with req held high, including an error in the chain.
    issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'h011, 32'h0000_00A5, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h011, 32'h0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h011, 32'h0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      wd = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h1000 | 32'($urandom_range(0, 4095));
        2, 3:    a = 32'($urandom_range(0, 4095));
        default: a = 32'($urandom_range(0, 4095)) & ~(32'(size_of(wd)) - 32'h1);
      endcase
      issue(1'($urandom_range(0, 1)), wd, 1'($urandom_range(0, 1)), a, $urandom,
            1'($urandom_range(0, 1)));
    end

    req = 1'b0;
    repeat (6) @(negedge clock);
    check("acc_queue_drained", acc_q.size(), 0);
    check("resp_queue_drained", resp_q.size(), 0);
    bad = 0;
    for (int w = 0; w < 1024; w++)
      if (ram[w] !== {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]}) bad++;
    check("ram_contents_bad_words", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
